// File: rtl/dmem_init_loader_pkg.sv
// Shared definitions for the data-memory boot loader: FSM state encoding,
// write-enable constants and a small state-decode helper.
package dmem_init_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam logic [3:0] WEN_FULL = 4'hf;
  localparam logic [3:0] WEN_NONE = 4'h0;

  // States in which the loader is collecting stream bytes.
  function automatic logic accepts_bytes(input state_e s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/dmem_init_loader_if.sv
// Byte-stream input and memory init-port output of the boot loader.
// master = stream source / memory side (bench), slave = loader.
interface dmem_init_loader_if;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        i_stall;
  logic [3:0]  o_init_wen;
  logic [31:0] o_init_addr;
  logic [31:0] o_init_data;
  logic        o_init_done;
  logic        o_error;

  modport master (
    output i_byte_valid, i_byte, i_stall,
    input  o_byte_ready, o_init_wen, o_init_addr, o_init_data, o_init_done, o_error
  );

  modport slave (
    input  i_byte_valid, i_byte, i_stall,
    output o_byte_ready, o_init_wen, o_init_addr, o_init_data, o_init_done, o_error
  );
endinterface

// File: rtl/dmem_init_loader_byte_word_assembler.sv
// Little-endian 32-bit field assembler. Counts accepted bytes with a 2-bit
// wrapping counter; on the 4th byte it strobes o_word_done for that same
// cycle with the completed word (the 4th byte forms bits [31:24]).
module byte_word_assembler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic        o_word_done,
  output logic [31:0] o_word
);

  logic [1:0]  cnt_q;
  logic [23:0] low_q;

  assign o_word_done = i_accept && (cnt_q == 2'd3);
  assign o_word      = {i_byte, low_q};

  // Byte position counter; wraps 3->0 as each field completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= 2'd0;
    else if (i_accept) cnt_q <= cnt_q + 2'd1;
  end

  // Capture the three low bytes of the field in their LE lanes.
  always_ff @(posedge i_clk) begin
    if (i_accept) begin
      case (cnt_q)
        2'd0:    low_q[7:0]   <= i_byte;
        2'd1:    low_q[15:8]  <= i_byte;
        2'd2:    low_q[23:16] <= i_byte;
        default: low_q        <= low_q;
      endcase
    end
  end

endmodule

// File: rtl/dmem_init_loader.sv
// Boot-time data-memory loader: parses a LE word-count header, assembles
// 32-bit words from the byte stream and writes them sequentially from
// BASE_ADDR. Optional build macro: DMEM_LOADER_CHECKSUM_EN adds a trailing
// 32-bit checksum (sum of written words mod 2^32) verified before done.
module dmem_init_loader
  import dmem_init_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input logic               i_clk,
  input logic               i_rst,
  dmem_init_loader_if.slave bus
);

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

`ifdef DMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_END = ST_CSUM;
`else
  localparam state_e ST_END = ST_DONE;
`endif

  state_e      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] n_q, n_d;
  logic [31:0] word;
  logic        word_done;
  logic        byte_fire;
  logic        wr_fire;

  assign byte_fire = bus.i_byte_valid && bus.o_byte_ready;
  assign wr_fire   = (state_q == ST_WRITE) && !bus.i_stall;

  byte_word_assembler u_asm (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_accept    (byte_fire),
    .i_byte      (bus.i_byte),
    .o_word_done (word_done),
    .o_word      (word)
  );

`ifdef DMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  // Running sum of every word the memory has accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) sum_q <= 32'd0;
    else if (wr_fire) sum_q <= sum_q + bus.o_init_data;
  end
`endif

  // Next-state logic: header parse, word collection, write handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    case (state_q)
      ST_HDR: begin
        if (word_done) begin
          n_d = word;
          if (word == 32'd0)      state_d = ST_END;
          else if (word > MAX_N)  state_d = ST_ERR;
          else                    state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_fire) begin
          idx_d   = idx_q + 32'd1;
          state_d = (idx_d == n_q) ? ST_END : ST_DATA;
        end
      end
`ifdef DMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (word_done) state_d = (word == sum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  // FSM state, word index and header count registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_HDR;
      idx_q   <= 32'd0;
      n_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_byte_ready <= 1'b1;
      bus.o_init_wen   <= WEN_NONE;
      bus.o_init_addr  <= BASE_ADDR;
      bus.o_init_data  <= 32'd0;
      bus.o_init_done  <= 1'b0;
      bus.o_error      <= 1'b0;
    end else begin
      bus.o_byte_ready <= accepts_bytes(state_d);
      bus.o_init_wen   <= (state_d == ST_WRITE) ? WEN_FULL : WEN_NONE;
      bus.o_init_addr  <= BASE_ADDR + {idx_d[29:0], 2'b00};
      if ((state_d == ST_WRITE) && (state_q != ST_WRITE))
        bus.o_init_data <= word;
      bus.o_init_done  <= (state_d == ST_DONE);
      bus.o_error      <= (state_d == ST_ERR);
    end
  end

endmodule

// File: doc/dmem_init_loader.md
# dmem_init_loader

Boot-time loader sitting directly upstream of the cached data memory's init port. It consumes a little-endian byte stream (from a UART receiver or a bench driver), parses a word-count header, assembles 32-bit words and writes them sequentially into data memory. When the image is complete it raises `o_init_done`, releasing the memory for use by the core.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written; must be 4-byte aligned.
- `MAX_WORDS`, 4096: largest accepted word count; a header above this is an error.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; synchronous and active-high.
- `i_byte_valid`  in  1  stream byte present.
- `i_byte`  in  8  stream byte.
- `o_byte_ready`  out  1  loader accepts a byte this cycle.
- `i_stall`  in  1  memory cannot take an init write this cycle.
- `o_init_wen`  out  4  byte write enables; 4'hf during a write, else 0.
- `o_init_addr`  out  32  word-aligned write address.
- `o_init_data`  out  32  write data.
- `o_init_done`  out  1  image fully loaded; sticky until reset.
- `o_error`  out  1  load aborted; sticky until reset.

## Operation
- A byte transfers on a cycle where `i_byte_valid && o_byte_ready`.
- All multi-byte fields are little-endian: the first byte goes to [7:0] and the fourth to [31:24].
- States:
  - HDR: collect 4 bytes into count N.
    - N == 0 goes to DONE (or to CSUM when checksum is enabled).
    - N > MAX_WORDS goes to ERR.
    - Otherwise go to DATA.
  - DATA: collect 4 bytes into a word, then go to WRITE.
  - WRITE: `o_init_wen`=4'hf, `o_init_addr`=BASE_ADDR + 4*idx, `o_init_data`=word.
    - The write is accepted on a cycle with `i_stall`=0.
    - On acceptance, idx increments. If idx reaches N, go to DONE (or CSUM); otherwise go to DATA.
  - DONE: `o_init_done`=1, no further writes.
  - ERR: `o_error`=1, no further writes.
- `o_byte_ready`=1 in HDR, DATA and CSUM. It is 0 in WRITE, DONE and ERR.
  - Bytes offered after DONE or ERR are never accepted.
- Byte counter is 2 bits and wraps 3→0 on field completion.
- idx is 32 bits; address arithmetic is modulo 2^32.
- While `i_stall` is high in WRITE, `o_init_wen`, `o_init_addr` and `o_init_data` are held unchanged.
- Reset at any point returns to HDR and clears the byte counter, idx, all outputs and the sticky flags.
  - Words already written stay in memory.

## Timing
- Reset values: `o_byte_ready`=1 (HDR), `o_init_wen`=0, `o_init_addr`=BASE_ADDR, `o_init_data`=0, `o_init_done`=0, `o_error`=0.
- All outputs are registered.
- 4th byte of a word accepted in cycle t:
  - cycle t+1: WRITE with `o_init_wen`=4'hf.
  - With `i_stall`=0, cycle t+2: `o_init_wen`=0 and `o_byte_ready`=1.
- Peak throughput is one word per 5 cycles.
- Last write accepted in cycle t: `o_init_done`=1 from cycle t+1 (checksum disabled).
- 4th header byte with N == 0 accepted in cycle t: `o_init_done`=1 from t+1.
- Error detected on byte accepted in cycle t: `o_error`=1 from t+1.
- `o_init_done` and `o_error` are never high together.

## Configuration
- `DMEM_LOADER_CHECKSUM_EN` defined:
  - After the N-th write, the CSUM state collects 4 more bytes.
  - They are compared with the running sum of all written words, mod 2^32.
  - Match goes to DONE; mismatch goes to ERR.
  - The running sum clears on reset.
- Not defined: no CSUM state; the loader goes straight to DONE after the N-th write (or after a header with N == 0).

## Structure
- Shared package holds:
  - the state encoding constants: HDR=0, DATA=1, WRITE=2, CSUM=3, DONE=4, ERR=5;
  - the full write-enable constant 4'hf.
- One natural sub-module: `byte_word_assembler`.
  - Contains the 2-bit counter and 32-bit LE shift/insert logic.
  - Emits a word-complete strobe and the assembled word.
  - Reused for the header, data and checksum fields.

## Test plan
- Header 01 00 00 00, data 78 56 34 12, `i_stall`=0:
  - one write, addr=BASE_ADDR, data=32'h12345678, wen=4'hf for exactly one cycle;
  - `o_init_done`=1 the next cycle.
- N=3, `i_stall` held high for 5 cycles on the second write:
  - addr/data held through the stall;
  - writes land at BASE+0, BASE+4, BASE+8 in order;
  - `o_byte_ready`=0 throughout the stall.
- Header 00 00 00 00: `o_init_done`=1 one cycle after the 4th byte; no write ever issued.
- Header with N=MAX_WORDS+1: `o_error`=1; `o_byte_ready`=0 and no writes thereafter.
- Assert `i_rst` after 2 of 4 words:
  - outputs return to reset values next cycle;
  - a fresh N=1 stream then writes BASE_ADDR correctly.
- With `DMEM_LOADER_CHECKSUM_EN`, N=2, words 1 and 2:
  - checksum 03 00 00 00 → `o_init_done`=1;
  - checksum 04 00 00 00 → `o_error`=1.
